// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with an integrated busy scoreboard.
// Issue reserves a destination; writeback stores data and releases it.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   r_reg,
    output logic [NRD*XLEN-1:0] r_dat,
    output logic [NRD-1:0]      r_busy,
    input  logic [AW-1:0]       w_reg,
    input  logic [XLEN-1:0]     w_dat,
    input  logic                write,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_reg,
    output logic                rsv_conflict,
    output logic [AW:0]         pending
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nx;
    logic [AW:0]      cnt_nx;
    logic             wr_en;
    logic             rsv_en;
    logic             conflict_nx;

    assign wr_en  = write && (w_reg != '0);
    assign rsv_en = rsv && (rsv_reg != '0);

    // Clear-then-set ordering lets a same-cycle reservation win over writeback.
    always_comb begin
        busy_nx = busy;
        if (wr_en) begin
            busy_nx[w_reg] = 1'b0;
        end
        if (rsv_en) begin
            busy_nx[rsv_reg] = 1'b1;
        end
    end

    always_comb begin
        cnt_nx = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nx = cnt_nx + {{AW{1'b0}}, busy_nx[i]};
        end
    end

    assign conflict_nx = rsv_en && busy[rsv_reg]
                         && !(wr_en && (w_reg == rsv_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            pending      <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[w_reg] <= w_dat;
            end
            busy         <= busy_nx;
            pending      <= cnt_nx;
            rsv_conflict <= conflict_nx;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] dat;
        logic            bsy;

        assign addr = r_reg[p*AW +: AW];

        always_comb begin
            dat = regs[addr];
            bsy = busy[addr];
            if (addr == '0) begin
                dat = '0;
                bsy = 1'b0;
            end else if ((BYPASS != 0) && write && (w_reg == addr)) begin
                dat = w_dat;
                bsy = 1'b0;
            end
        end

        assign r_dat[p*XLEN +: XLEN] = dat;
        assign r_busy[p]             = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, corner
// sequences and random traffic against a behavioural model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            write;
    logic            rsv;
    logic [AW-1:0]   w_reg;
    logic [AW-1:0]   rsv_reg;
    logic [XLEN-1:0] w_dat;

    logic [4*AW-1:0]   r_reg_a;
    logic [4*XLEN-1:0] r_dat_a;
    logic [3:0]        r_busy_a;
    logic              conf_a;
    logic [AW:0]       pend_a;

    logic [2*AW-1:0]   r_reg_b;
    logic [2*XLEN-1:0] r_dat_b;
    logic [1:0]        r_busy_b;
    logic              conf_b;
    logic [AW:0]       pend_b;

    assign r_reg_b = r_reg_a[2*AW-1:0];

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(4), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .r_reg(r_reg_a), .r_dat(r_dat_a), .r_busy(r_busy_a),
        .w_reg(w_reg), .w_dat(w_dat), .write(write),
        .rsv(rsv), .rsv_reg(rsv_reg),
        .rsv_conflict(conf_a), .pending(pend_a)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .r_reg(r_reg_b), .r_dat(r_dat_b), .r_busy(r_busy_b),
        .w_reg(w_reg), .w_dat(w_dat), .write(write),
        .rsv(rsv), .rsv_reg(rsv_reg),
        .rsv_conflict(conf_b), .pending(pend_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              m_pend;
    bit              m_conf;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_rdat(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && write && int'(w_reg) == a) return w_dat;
        return m_regs[a];
    endfunction

    function automatic bit m_rbusy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && write && int'(w_reg) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_edge();
        int n;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            m_conf = rsv && rsv_reg != 0 && m_busy[rsv_reg]
                     && !(write && w_reg == rsv_reg);
            if (write && w_reg != 0) begin
                m_regs[w_reg] = w_dat;
                m_busy[w_reg] = 1'b0;
            end
            if (rsv && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
        end
        n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        m_pend = n;
    endtask

    task automatic check_reads();
        int a;
        for (int p = 0; p < 4; p++) begin
            a = int'(r_reg_a[p*AW +: AW]);
            chk($sformatf("a_dat%0d", p), r_dat_a[p*XLEN +: XLEN], m_rdat(a, 1'b1));
            chk($sformatf("a_busy%0d", p), 32'(r_busy_a[p]), 32'(m_rbusy(a, 1'b1)));
        end
        for (int p = 0; p < 2; p++) begin
            a = int'(r_reg_b[p*AW +: AW]);
            chk($sformatf("b_dat%0d", p), r_dat_b[p*XLEN +: XLEN], m_rdat(a, 1'b0));
            chk($sformatf("b_busy%0d", p), 32'(r_busy_b[p]), 32'(m_rbusy(a, 1'b0)));
        end
    endtask

    task automatic step();
        #1;
        check_reads();
        @(posedge clk);
        m_edge();
        #1;
        chk("a_pending", 32'(pend_a), 32'(m_pend));
        chk("b_pending", 32'(pend_b), 32'(m_pend));
        chk("a_conflict", 32'(conf_a), 32'(m_conf));
        chk("b_conflict", 32'(conf_b), 32'(m_conf));
    endtask

    task automatic idle();
        write = 0; rsv = 0; rst = 0;
        w_reg = '0; rsv_reg = '0; w_dat = '0;
    endtask

    typedef struct {
        bit          wr;
        int          wreg;
        logic [31:0] wdat;
        bit          rs;
        int          rreg;
        int          rd;
        logic [31:0] exp_dat;
        bit          exp_busy;
        int          exp_pend;
        bit          exp_conf;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0,        0, 0, 5, 32'hDEADBEEF, 0, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,        1, 7, 7, 32'h0,        0, 1, 0};
        vecs[3]  = '{0, 0, 32'h0,        0, 0, 7, 32'h0,        1, 1, 0};
        vecs[4]  = '{0, 0, 32'h0,        0, 0, 7, 32'h0,        1, 1, 0};
        vecs[5]  = '{1, 7, 32'h1234,     0, 0, 7, 32'h1234,     0, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,        0, 0, 7, 32'h1234,     0, 0, 0};
        vecs[7]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,        1, 9, 9, 32'h0,        0, 1, 0};
        vecs[9]  = '{0, 0, 32'h0,        1, 9, 9, 32'h0,        1, 1, 1};
        vecs[10] = '{1, 9, 32'h55,       1, 9, 9, 32'h55,       0, 1, 0};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 9, 32'h55,       1, 1, 0};

        idle();
        rst = 1;
        r_reg_a = '0;
        @(posedge clk);
        m_edge();
        #1;

        // Reset state on every address and port
        for (int a = 0; a < NREGS; a++) begin
            r_reg_a = {4{5'(a)}};
            #1;
            for (int p = 0; p < 4; p++) begin
                chk("rst_dat", r_dat_a[p*XLEN +: XLEN], 32'h0);
                chk("rst_busy", 32'(r_busy_a[p]), 32'h0);
            end
            step();
        end
        chk("rst_pending", 32'(pend_a), 32'h0);
        idle();

        for (int i = 0; i < 12; i++) begin
            write   = vecs[i].wr;
            w_reg   = 5'(vecs[i].wreg);
            w_dat   = vecs[i].wdat;
            rsv     = vecs[i].rs;
            rsv_reg = 5'(vecs[i].rreg);
            r_reg_a = {4{5'(vecs[i].rd)}};
            #1;
            chk($sformatf("vec%0d_dat", i), r_dat_a[XLEN-1:0], vecs[i].exp_dat);
            chk($sformatf("vec%0d_busy", i), 32'(r_busy_a[0]), 32'(vecs[i].exp_busy));
            step();
            chk($sformatf("vec%0d_pend", i), 32'(pend_a), 32'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_conf", i), 32'(conf_a), 32'(vecs[i].exp_conf));
        end

        // Non-bypass port keeps old data until the edge
        idle();
        rsv = 1; rsv_reg = 5'd12; step();
        idle();
        write = 1; w_reg = 5'd12; w_dat = 32'hCAFE0001;
        r_reg_a = {4{5'd12}};
        #1;
        chk("nobyp_old_dat", r_dat_b[XLEN-1:0], 32'h0);
        chk("nobyp_old_busy", 32'(r_busy_b[0]), 32'h1);
        step();
        idle();
        #1;
        chk("nobyp_new_dat", r_dat_b[XLEN-1:0], 32'hCAFE0001);
        chk("nobyp_new_busy", 32'(r_busy_b[0]), 32'h0);
        step();

        // Four ports bypassing one register
        write = 1; w_reg = 5'd3; w_dat = 32'hA5A5A5A5;
        r_reg_a = {4{5'd3}};
        #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("all4_dat%0d", p), r_dat_a[p*XLEN +: XLEN], 32'hA5A5A5A5);
        step();
        idle();

        // Fill the scoreboard
        for (int r = 1; r < NREGS; r++) begin
            rsv = 1; rsv_reg = 5'(r);
            step();
        end
        idle();
        chk("fill_pending", 32'(pend_a), 32'd31);

        // Reset during a reservation run discards a concurrent write
        rst = 1; step(); idle();
        for (int r = 1; r < 16; r++) begin
            rsv = 1; rsv_reg = 5'(r);
            step();
        end
        rst = 1; rsv = 1; rsv_reg = 5'd16;
        write = 1; w_reg = 5'd4; w_dat = 32'h77777777;
        step();
        idle();
        chk("midrst_pending", 32'(pend_a), 32'h0);
        for (int a = 0; a < NREGS; a++) begin
            r_reg_a = {4{5'(a)}};
            #1;
            chk("midrst_dat", r_dat_a[XLEN-1:0], 32'h0);
            chk("midrst_busy", 32'(r_busy_a[0]), 32'h0);
            step();
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            write   = $urandom_range(0, 1) == 1;
            rsv     = $urandom_range(0, 1) == 1;
            w_reg   = 5'($urandom);
            rsv_reg = ($urandom_range(0, 3) == 0) ? w_reg : 5'($urandom);
            w_dat   = $urandom;
            r_reg_a = 20'($urandom);
            if ($urandom_range(0, 2) == 0) r_reg_a[AW-1:0] = w_reg;
            if ($urandom_range(0, 3) == 0) r_reg_a[2*AW-1:AW] = rsv_reg;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with integrated scoreboard and optional write-to-read bypass.
- Sits between decode/issue and writeback in the pipelined core.
- Issue reserves a destination register (marks it busy). Writeback writes data and clears busy.
- Read ports return data plus a busy flag so issue logic can stall on RAW hazards without a separate scoreboard block.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2; register 0 is hardwired zero.
- NRD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see only stored contents.
- Derived (not overridable): AW = $clog2(NREGS).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- r_reg  input  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- r_dat  output  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]; combinational.
- r_busy  output  NRD  per-port busy flag; combinational.
- w_reg  input  AW  writeback address.
- w_dat  input  XLEN  writeback data.
- write  input  1  writeback enable.
- rsv  input  1  reserve enable (issue of an instruction with a destination).
- rsv_reg  input  AW  register to reserve.
- rsv_conflict  output  1  registered; pulses 1 cycle after a reserve of an already-busy register.
- pending  output  AW+1  registered count of busy registers.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - All registers cleared to 0; all busy bits cleared.
  - pending=0, rsv_conflict=0.
  - rst overrides write and rsv in the same cycle.
- Register 0:
  - Always reads 0 and r_busy=0.
  - Writes to 0 are ignored.
  - Reserves of 0 are ignored: no busy bit set, no pending change, no conflict.
- Write: if write=1 and w_reg!=0, regs[w_reg] <= w_dat at the edge and busy[w_reg] is cleared. A write to a non-busy register is legal and still updates data.
- Reserve: if rsv=1 and rsv_reg!=0, busy[rsv_reg] <= 1 at the edge.
- rsv_conflict <= rsv & (rsv_reg!=0) & busy[rsv_reg] & ~(write & w_reg==rsv_reg).
  - Evaluated on pre-edge state.
  - Busy remains set on a conflict; the reservation is still accepted.
- Simultaneous write and rsv to the same nonzero register: data is written, busy ends SET (the new reservation wins), and there is no conflict.
- pending is the population count of busy bits, updated each edge:
  - +1 when a nonzero reserve sets a previously clear bit.
  - -1 when a write clears a set bit that is not re-reserved.
  - Net 0 when both occur on different registers.
  - Never exceeds NREGS-1.
- Read port i, addr a = r_reg[i]:
  - a==0 -> r_dat=0, r_busy=0.
  - BYPASS=1 and write=1 and w_reg==a -> r_dat=w_dat, r_busy=0 (writeback satisfies the hazard this cycle).
  - Otherwise r_dat=regs[a], r_busy=busy[a].
  - A same-cycle rsv does not affect reads until the next cycle.
  - With BYPASS=0, reads return the old value and the old busy bit until the edge.
- All read ports are independent; any number may address the same register.
- Storage is flip-flop based (asynchronous read), with no read latency.

Test Plan:
- Reset then read all addresses on every port -> r_dat=0, r_busy=0, pending=0; then write 5<=32'hDEADBEEF -> next cycle port0 reg5 reads DEADBEEF, r_busy=0.
- rsv reg 7 at cycle N -> cycle N+1 r_busy=1 on port reading 7 and pending=1; write 7<=32'h1234 at N+3 -> with BYPASS=1, r_dat=1234 and r_busy=0 in cycle N+3; pending=0 at N+4. Repeat with BYPASS=0 -> old data and busy=1 in N+3, new data at N+4.
- Write reg 0 <= FFFFFFFF with rsv reg 0 -> reg0 reads 0, r_busy=0, pending unchanged, rsv_conflict=0.
- rsv 9 twice on consecutive cycles -> rsv_conflict=1 one cycle after the second reserve, pending=1. Then same-cycle write 9 + rsv 9 -> data updated, busy stays 1, rsv_conflict=0, pending=1.
- Reserve regs 1..31 consecutively -> pending=31. Assert rst mid-sequence with write=1 -> next cycle all data 0, all busy 0, pending=0, write discarded.
- NRD=4, all ports address reg 3 while write 3<=A5A5A5A5 with BYPASS=1 -> all four r_dat=A5A5A5A5 in the same cycle.
